window_3x3_stream: RTL and testbench

- Sits directly downstream of the frame Buffer in the edge-detection pipeline.
- Consumes the Buffer's raster-order pixel stream (one pixel per accepted cycle, row-major, WIDTH x HEIGHT frame) and emits a 3x3 neighbourhood for every interior pixel.
- Later filter and threshold stages consume this window.
- Holds two line buffers plus a 3x3 shift window; border pixels produce no window.

---
 rtl/window_3x3_stream.sv | 152 +++++++++++++++
 tb/tb_window_3x3_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_stream.sv
// 3x3 sliding-window generator for a raster pixel stream: two line buffers
// feed a 3x3 shift window, and a window is emitted only for interior pixels.
module window_3x3_stream #(
    parameter int DATA_W = 1,
    parameter int WIDTH  = 150,
    parameter int HEIGHT = 150,
    parameter int CNT_W  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enb,
    input  logic                  pix_valid,
    input  logic [DATA_W-1:0]     pix_in,
    output logic [9*DATA_W-1:0]   window,
    output logic                  win_valid,
    output logic [7:0]            row_c,
    output logic [7:0]            col_c,
    output logic                  frame_done
);

    localparam int LAST_IDX = WIDTH * HEIGHT - 1;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         col_q, col_d;
    logic [7:0]         row_q, row_d;
    logic [CNT_W-1:0]   pix_idx_q, pix_idx_d;
    logic [DATA_W-1:0]  lb0_q [WIDTH];
    logic [DATA_W-1:0]  lb0_d [WIDTH];
    logic [DATA_W-1:0]  lb1_q [WIDTH];
    logic [DATA_W-1:0]  lb1_d [WIDTH];
    logic [DATA_W-1:0]  win_q [3][3];
    logic [DATA_W-1:0]  win_d [3][3];
    logic               win_valid_q, win_valid_d;
    logic [7:0]         row_c_q, row_c_d;
    logic [7:0]         col_c_q, col_c_d;
    logic               frame_done_q, frame_done_d;

    logic accept;
    logic last_pix;

    assign accept   = enb && pix_valid;
    assign last_pix = (pix_idx_q == CNT_W'(LAST_IDX));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        pix_idx_d    = pix_idx_q;
        lb0_d        = lb0_q;
        lb1_d        = lb1_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        row_c_d      = row_c_q;
        col_c_d      = col_c_q;
        frame_done_d = 1'b0;

        if (accept) begin
            // Reads of lb0_q/lb1_q see the pre-write contents of this column.
            lb1_d[col_q] = lb0_q[col_q];
            lb0_d[col_q] = pix_in;
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb1_q[col_q];
            win_d[1][2] = lb0_q[col_q];
            win_d[2][2] = pix_in;

            if (row_q >= 8'd2 && col_q >= 8'd2) begin
                win_valid_d = 1'b1;
                row_c_d     = row_q - 8'd1;
                col_c_d     = col_q - 8'd1;
            end

            if (last_pix) begin
                col_d        = '0;
                row_d        = '0;
                pix_idx_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                pix_idx_d = pix_idx_q + CNT_W'(1);
                if (col_q == 8'(WIDTH - 1)) begin
                    col_d = '0;
                    row_d = row_q + 8'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
        end

        unique case (state_q)
            IDLE:   if (accept) state_d = FILL;
            FILL:   if (accept && row_q == 8'd2) state_d = STREAM;
            STREAM: if (accept && last_pix) state_d = DONE;
            DONE:   state_d = accept ? FILL : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            pix_idx_q    <= '0;
            win_valid_q  <= 1'b0;
            row_c_q      <= '0;
            col_c_q      <= '0;
            frame_done_q <= 1'b0;
            // NOTE: the line buffers are built from flops and are cleared with everything else, so no state survives a reset.
            for (int k = 0; k < WIDTH; k++) begin
                lb0_q[k] <= '0;
                lb1_q[k] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples its pre-edge _d value.
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pix_idx_q    <= pix_idx_d;
            lb0_q        <= lb0_d;
            lb1_q        <= lb1_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            row_c_q      <= row_c_d;
            col_c_q      <= col_c_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        window = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                window[DATA_W*(3*i+j) +: DATA_W] = win_q[i][j];
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign row_c      = row_c_q;
    assign col_c      = col_c_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3_stream.sv
// Directed bench for window_3x3_stream: a 2-D image model supplies expected
// windows, plus hand-computed checks at the first window, row edges and frame ends.
module tb_window_3x3_stream;

    localparam int W = 150;
    localparam int H = 150;
    localparam int N = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       reset;
    logic       enb;
    logic       pix_valid;
    logic [0:0] pix_in;
    logic [8:0] window;
    logic       win_valid;
    logic [7:0] row_c;
    logic [7:0] col_c;
    logic       frame_done;

    window_3x3_stream dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .window     (window),
        .win_valid  (win_valid),
        .row_c      (row_c),
        .col_c      (col_c),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Image model of the frame in flight and the expected outputs for the last edge.
    logic       img [H][W];
    int         m_row, m_col, m_idx, acc_idx, tot_acc;
    logic       exp_valid, exp_done;
    logic [8:0] exp_win;
    int         exp_row, exp_col;
    int         done_at_ramp;

    // Drive one cycle, step the model for that edge, and leave time at edge+1.
    task automatic step(input logic en, input logic v, input logic p);
        enb       = en;
        pix_valid = v;
        pix_in    = p;
        @(posedge clk);
        if (en && v) begin
            img[m_row][m_col] = p;
            exp_valid = (m_row >= 2 && m_col >= 2);
            if (exp_valid) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_win[3*i+j] = img[m_row-2+i][m_col-2+j];
                exp_row = m_row - 1;
                exp_col = m_col - 1;
            end
            exp_done = (m_idx == N - 1);
            acc_idx  = m_idx;
            tot_acc++;
            if (m_idx == N - 1) begin
                m_idx = 0; m_row = 0; m_col = 0;
            end else begin
                m_idx++;
                if (m_col == W - 1) begin m_col = 0; m_row++; end
                else m_col++;
            end
        end else begin
            exp_valid = 1'b0;
            exp_done  = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enb = 1'b0; pix_valid = 1'b0; pix_in = '0;
        m_row = 0; m_col = 0; m_idx = 0; tot_acc = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (window !== 9'h000)   begin n_bad++; $display("FAIL reset_window got %h want 000", window); end
        n_cmp++; if (win_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_win_valid got %b want 0", win_valid); end
        n_cmp++; if (row_c !== 8'd0)      begin n_bad++; $display("FAIL reset_row_c got %0d want 0", row_c); end
        n_cmp++; if (col_c !== 8'd0)      begin n_bad++; $display("FAIL reset_col_c got %0d want 0", col_c); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        reset = 1'b0;
    endtask

    // Ramp frame pix = idx[0]; since W is even that is column parity.
    task automatic test_ramp();
        int   n_win = 0, n_done = 0, done_idx = -1, first_idx = -1;
        int   first_r = -1, first_c = -1, range_bad = 0;
        logic first_seen = 1'b0, after_edge = 1'b0, wrap_checked = 1'b0;
        logic [8:0] first_win = '0;
        for (int idx = 0; idx < N; idx++) begin
            step(1'b1, 1'b1, idx[0]);
            n_cmp++;
            if (win_valid !== exp_valid || frame_done !== exp_done ||
                (exp_valid && (window !== exp_win || row_c !== 8'(exp_row) || col_c !== 8'(exp_col)))) begin
                n_bad++;
                $display("FAIL ramp_cycle idx=%0d got v=%b d=%b w=%h r=%0d c=%0d want v=%b d=%b w=%h r=%0d c=%0d",
                         acc_idx, win_valid, frame_done, window, row_c, col_c, exp_valid, exp_done, exp_win, exp_row, exp_col);
            end
            if (win_valid === 1'b1) begin
                n_win++;
                if (col_c == 8'd0 || col_c > 8'd148 || row_c == 8'd0 || row_c > 8'd148) range_bad++;
                if (!first_seen) begin
                    first_seen = 1'b1; first_idx = acc_idx;
                    first_r = row_c; first_c = col_c; first_win = window;
                end
                if (after_edge && !wrap_checked) begin
                    wrap_checked = 1'b1;
                    n_cmp++;
                    if (row_c !== 8'd2 || col_c !== 8'd1 || window !== 9'h092) begin
                        n_bad++;
                        $display("FAIL ramp_row_wrap got r=%0d c=%0d w=%h want r=2 c=1 w=092", row_c, col_c, window);
                    end
                end
                if (row_c == 8'd1 && col_c == 8'd148) begin
                    after_edge = 1'b1;
                    n_cmp++;
                    if (window !== 9'h16D) begin
                        n_bad++;
                        $display("FAIL ramp_right_edge got w=%h want 16d", window);
                    end
                end
            end
            if (frame_done === 1'b1) begin n_done++; done_idx = acc_idx; done_at_ramp = tot_acc; end
        end
        n_cmp++; if (first_idx != 302) begin n_bad++; $display("FAIL ramp_first_idx got %0d want 302", first_idx); end
        n_cmp++; if (first_r != 1 || first_c != 1) begin n_bad++; $display("FAIL ramp_first_pos got %0d,%0d want 1,1", first_r, first_c); end
        n_cmp++; if (first_win !== 9'h092) begin n_bad++; $display("FAIL ramp_first_win got %h want 092", first_win); end
        n_cmp++; if (n_win != NWIN) begin n_bad++; $display("FAIL ramp_win_count got %0d want %0d", n_win, NWIN); end
        n_cmp++; if (n_done != 1 || done_idx != N - 1) begin n_bad++; $display("FAIL ramp_frame_done got %0d pulses at %0d want 1 at %0d", n_done, done_idx, N - 1); end
        n_cmp++; if (range_bad != 0) begin n_bad++; $display("FAIL ramp_range got %0d out-of-range windows want 0", range_bad); end
        n_cmp++; if (!wrap_checked) begin n_bad++; $display("FAIL ramp_row_wrap_seen got 0 want 1"); end
    endtask

    // Inverted frame started in the DONE cycle of the ramp frame.
    task automatic test_back_to_back();
        int   n_win = 0, n_done = 0, done_at = -1;
        logic first_seen = 1'b0;
        for (int idx = 0; idx < N; idx++) begin
            step(1'b1, 1'b1, ~idx[0]);
            n_cmp++;
            if (win_valid !== exp_valid || frame_done !== exp_done ||
                (exp_valid && (window !== exp_win || row_c !== 8'(exp_row) || col_c !== 8'(exp_col)))) begin
                n_bad++;
                $display("FAIL b2b_cycle idx=%0d got v=%b d=%b w=%h r=%0d c=%0d want v=%b d=%b w=%h r=%0d c=%0d",
                         acc_idx, win_valid, frame_done, window, row_c, col_c, exp_valid, exp_done, exp_win, exp_row, exp_col);
            end
            if (win_valid === 1'b1) begin
                n_win++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    n_cmp++;
                    if (row_c !== 8'd1 || col_c !== 8'd1 || window !== 9'h16D) begin
                        n_bad++;
                        $display("FAIL b2b_first_win got r=%0d c=%0d w=%h want r=1 c=1 w=16d", row_c, col_c, window);
                    end
                end
            end
            if (frame_done === 1'b1) begin n_done++; done_at = tot_acc; end
        end
        n_cmp++; if (n_win != NWIN) begin n_bad++; $display("FAIL b2b_win_count got %0d want %0d", n_win, NWIN); end
        n_cmp++; if (n_done != 1 || done_at - done_at_ramp != N) begin n_bad++; $display("FAIL b2b_done_spacing got %0d pulses %0d apart want 1 pulse %0d apart", n_done, done_at - done_at_ramp, N); end
    endtask

    // Random data with gaps and enb bursts, then an async reset after 5000 accepts.
    task automatic test_gapped_reset();
        int   acc = 0, burst = 0, idle_bad = 0;
        logic en, v, p;
        while (acc < 5000) begin
            if (acc < 2000) begin
                if (burst > 0) begin en = 1'b0; burst--; end
                else if ($urandom_range(0, 29) == 0) begin en = 1'b0; burst = 4; end
                else en = 1'b1;
                v = 1'($urandom_range(0, 1));
            end else begin
                en = 1'b1; v = 1'b1;
            end
            p = 1'($urandom_range(0, 1));
            step(en, v, p);
            if (en && v) acc++;
            else if (win_valid !== 1'b0) idle_bad++;
            n_cmp++;
            if (win_valid !== exp_valid || frame_done !== exp_done ||
                (exp_valid && (window !== exp_win || row_c !== 8'(exp_row) || col_c !== 8'(exp_col)))) begin
                n_bad++;
                $display("FAIL gapped_cycle idx=%0d got v=%b d=%b w=%h r=%0d c=%0d want v=%b d=%b w=%h r=%0d c=%0d",
                         acc_idx, win_valid, frame_done, window, row_c, col_c, exp_valid, exp_done, exp_win, exp_row, exp_col);
            end
        end
        n_cmp++; if (idle_bad != 0) begin n_bad++; $display("FAIL gapped_idle got %0d idle windows want 0", idle_bad); end
        n_cmp++; if (win_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid got %b want 1", win_valid); end
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if (window !== 9'h000 || win_valid !== 1'b0 || row_c !== 8'd0 || col_c !== 8'd0 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL midframe_reset got w=%h v=%b r=%0d c=%0d d=%b want all 0", window, win_valid, row_c, col_c, frame_done);
        end
        #1 reset = 1'b0;
        m_row = 0; m_col = 0; m_idx = 0;
    endtask

    // Fresh frame after reset: only pixel (10,20) is set.
    task automatic test_single_hot();
        int n_win = 0, n_nz = 0, nz_bad = 0, n_done = 0, first_idx = -1;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, 1'b1, (r == 10 && c == 20));
                n_cmp++;
                if (win_valid !== exp_valid || frame_done !== exp_done ||
                    (exp_valid && (window !== exp_win || row_c !== 8'(exp_row) || col_c !== 8'(exp_col)))) begin
                    n_bad++;
                    $display("FAIL hot_cycle idx=%0d got v=%b d=%b w=%h r=%0d c=%0d want v=%b d=%b w=%h r=%0d c=%0d",
                             acc_idx, win_valid, frame_done, window, row_c, col_c, exp_valid, exp_done, exp_win, exp_row, exp_col);
                end
                if (frame_done === 1'b1) n_done++;
                if (win_valid === 1'b1) begin
                    n_win++;
                    if (first_idx < 0) first_idx = acc_idx;
                    if (window !== 9'h000) begin
                        n_nz++;
                        if (row_c < 8'd9 || row_c > 8'd11 || col_c < 8'd19 || col_c > 8'd21) nz_bad++;
                    end
                    if (row_c == 8'd10 && col_c == 8'd20) begin
                        n_cmp++;
                        if (window !== 9'h010) begin n_bad++; $display("FAIL hot_centre got %h want 010", window); end
                    end
                    if (row_c == 8'd9 && col_c == 8'd19) begin
                        n_cmp++;
                        if (window !== 9'h100) begin n_bad++; $display("FAIL hot_corner got %h want 100", window); end
                    end
                end
            end
        end
        n_cmp++; if (n_nz != 9 || nz_bad != 0) begin n_bad++; $display("FAIL hot_nonzero got %0d (%0d misplaced) want 9 (0)", n_nz, nz_bad); end
        n_cmp++; if (n_win != NWIN) begin n_bad++; $display("FAIL hot_win_count got %0d want %0d", n_win, NWIN); end
        n_cmp++; if (first_idx != 302) begin n_bad++; $display("FAIL hot_first_idx got %0d want 302", first_idx); end
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL hot_frame_done got %0d want 1", n_done); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_gapped_reset();
        test_single_hot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
